memory_control: RTL and testbench
=================================

# memory_control

Memory controller at the far end of the cache-to-memory interface: services the instruction-cache read port and the data-cache read/write port, arbitrates between them, and drives a single-ported RAM. Sits between the `caches` block (icache + dcache) and the RAM model. Returns per-port wait/load responses. One RAM transaction is in flight at a time.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while an instruction read waits. Used only when the fairness guard is compiled in; legal range 1–15.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: synchronous, active-low reset.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `iwait` out 1: icache stall; 0 only in the completing cycle.
- `iload` out 32: instruction data; valid when `iwait`=0.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in 32: dcache word address.
- `dstore` in 32: write data.
- `dwait` out 1: dcache stall; 0 only in the completing cycle.
- `dload` out 32: data read result; valid when `dwait`=0.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `mem_err` out 1: sticky flag, set on any ERROR completion.

## Operation
- FSM states: IDLE, IREAD, DREAD, DWRITE.
- IDLE: drives no RAM strobes and holds `iwait`=`dwait`=1. If any request is present, registers the grant and moves to the matching state on the next edge.
- Arbitration when leaving IDLE:
  - `dWEN` → DWRITE. Writes win over reads when `dREN` and `dWEN` are both 1.
  - Otherwise `dREN` → DREAD.
  - Otherwise `iREN` → IREAD.
  - Data has strict priority over instruction unless the fairness guard overrides it.
- IREAD and DREAD:
  - Drive `ramREN`=1 and `ramaddr` from the granted port's address, passed through combinationally.
  - On `ramstate`=ACCESS: the granted port's wait goes to 0 and its load = `ramload` in the same cycle; next state is IDLE.
- DWRITE:
  - Drives `ramWEN`=1, `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - On ACCESS: `dwait`=0; next state is IDLE.
- ERROR in any active state:
  - Completes the transaction with wait=0 and load=0.
  - Sets `mem_err`. `mem_err` clears only on reset.
- FREE/BUSY in an active state: hold the state and keep the strobes asserted.
- Requester drops its request mid-transaction: the strobe deasserts in that same cycle, wait stays 1, and the FSM returns to IDLE on the next edge. No completion is reported.
- Non-granted port: wait=1 and load=0 at all times.
- Addresses and data pass through unmodified at 32 bits; no alignment checks.

## Timing
- Reset (`nRST`=0 at an edge): state=IDLE, `mem_err`=0, starvation counter=0.
- All outputs at reset: `iwait`=`dwait`=1, `iload`=`dload`=0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
- Reset asserted mid-transaction aborts it. Strobes drop after that edge and no completion is reported.
- Minimum latency is 2 cycles from request to wait=0:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: strobe asserted. If RAM returns ACCESS immediately, wait=0 in cycle 1.
- Each extra BUSY cycle adds one cycle of latency.
- After a completion there is always one IDLE cycle before the next grant. Back-to-back requests therefore complete at most every 2 cycles, plus RAM latency.

## Configuration
- `MEMCTRL_FAIRNESS_EN` defined:
  - A 4-bit counter increments on each data grant taken while `iREN`=1.
  - The counter resets on any instruction grant, or on any data grant taken while `iREN`=0.
  - When the counter equals `STARVE_LIMIT` and `iREN`=1, the next grant goes to IREAD regardless of pending data requests.
- `MEMCTRL_FAIRNESS_EN` undefined: strict data priority, no counter, and `STARVE_LIMIT` is ignored.

## Structure
- `cpu_types_pkg` holds:
  - `word_t` (32-bit).
  - `ramstate_t` enum (FREE/BUSY/ACCESS/ERROR).
  - `memctrl_state_t` enum (IDLE/IREAD/DREAD/DWRITE).
- Sub-module `mem_arbiter`: combinational grant selection from `iREN`/`dREN`/`dWEN`, plus the fairness counter under the macro. Top level holds the FSM and the output muxing.

## Test plan
- `iREN`=1, `iaddr`=0x0000_0040, RAM returns ACCESS on the 1st strobe cycle with `ramload`=0x2401_0005 → `ramREN`=1 in cycle 1; `iwait`=0 and `iload`=0x2401_0005 in cycle 1; state IDLE in cycle 2.
- `iREN`=`dREN`=1 together, RAM with 2 BUSY cycles before ACCESS → data is served first (`dwait`=0 in cycle 3, `iwait` still 1); instruction completes in cycle 7.
- `dREN`=`dWEN`=1, `daddr`=0x100, `dstore`=0xDEAD_BEEF → `ramWEN`=1, `ramREN`=0, `ramstore`=0xDEAD_BEEF; `dwait`=0 on ACCESS.
- `ramstate`=ERROR during DREAD → `dwait`=0, `dload`=0, `mem_err`=1; `mem_err` stays 1 through later good transactions until `nRST`=0.
- `nRST` pulsed low while in DWRITE with RAM BUSY → after that edge: `ramWEN`=0, `dwait`=1, `mem_err`=0, state IDLE.
- `MEMCTRL_FAIRNESS_EN` defined with `STARVE_LIMIT`=2, `dREN` and `iREN` held continuously → grant order D, D, I, D, D, I.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-memory path: bus word, RAM handshake
// state and memory controller FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IREAD  = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } memctrl_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Grant selection between icache and dcache requests. With MEMCTRL_FAIRNESS_EN
// defined, a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_iren,
  input  logic           i_dren,
  input  logic           i_dwen,
  input  logic           i_take,
  output memctrl_state_t o_grant
);

`ifdef MEMCTRL_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;
  logic       w_force_i;

  assign w_force_i = i_iren && (r_starve == LIMIT);

  always_comb begin
    o_grant = IDLE;
    if (w_force_i)   o_grant = IREAD;
    else if (i_dwen) o_grant = DWRITE;
    else if (i_dren) o_grant = DREAD;
    else if (i_iren) o_grant = IREAD;
  end

  // Counts only data grants that left an instruction request waiting.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_starve <= 4'd0;
    end else if (i_take && (o_grant != IDLE)) begin
      if (o_grant == IREAD) r_starve <= 4'd0;
      else if (i_iren)      r_starve <= r_starve + 4'd1;
      else                  r_starve <= 4'd0;
    end
  end
`else
  localparam logic [3:0] unused_limit = 4'(STARVE_LIMIT);
  logic w_unused_ok;

  assign w_unused_ok = &{1'b0, i_clk, i_rst_n, i_take};

  always_comb begin
    o_grant = IDLE;
    if (i_dwen)      o_grant = DWRITE;
    else if (i_dren) o_grant = DREAD;
    else if (i_iren) o_grant = IREAD;
  end
`endif

endmodule

// File: rtl/memory_control.sv
// Memory controller: arbitrates icache/dcache requests onto a single-ported RAM,
// one transaction in flight. Optional MEMCTRL_FAIRNESS_EN enables the starvation guard.
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  memctrl_state_t r_state;
  memctrl_state_t w_next;
  memctrl_state_t w_grant;
  ramstate_t      w_ram;
  logic           r_mem_err;
  logic           w_err;

  assign w_ram   = ramstate_t'(ramstate);
  assign mem_err = r_mem_err;

  mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .i_clk  (CLK),
    .i_rst_n(nRST),
    .i_iren (iREN),
    .i_dren (dREN),
    .i_dwen (dWEN),
    .i_take (r_state == IDLE),
    .o_grant(w_grant)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_err <= r_mem_err | w_err;
    end
  end

  // A dropped request abandons the transaction silently; ERROR completes it with zero data.
  always_comb begin
    w_next   = r_state;
    w_err    = 1'b0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      IDLE: begin
        w_next = w_grant;
      end
      IREAD: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (w_ram == ACCESS) begin
            iwait  = 1'b0;
            iload  = ramload;
            w_next = IDLE;
          end else if (w_ram == ERROR) begin
            iwait  = 1'b0;
            w_err  = 1'b1;
            w_next = IDLE;
          end
        end
      end
      DREAD: begin
        if (!dREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = daddr;
          if (w_ram == ACCESS) begin
            dwait  = 1'b0;
            dload  = ramload;
            w_next = IDLE;
          end else if (w_ram == ERROR) begin
            dwait  = 1'b0;
            w_err  = 1'b1;
            w_next = IDLE;
          end
        end
      end
      DWRITE: begin
        if (!dWEN) begin
          w_next = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
          if (w_ram == ACCESS) begin
            dwait  = 1'b0;
            w_next = IDLE;
          end else if (w_ram == ERROR) begin
            dwait  = 1'b0;
            w_err  = 1'b1;
            w_next = IDLE;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Directed self-checking bench for memory_control; the fairness scenario
// follows whether MEMCTRL_FAIRNESS_EN is defined.
module tb_memory_control;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  memory_control #(
    .STARVE_LIMIT(2)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .mem_err (mem_err)
  );

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hA5A5_5A5A; ramstate = FREE;
    nextCycle(); nextCycle(); sample();
    checks++;
    if ({iwait, dwait} !== 2'b11) begin
      $display("[TB] FAIL reset_wait: got %b expected 11", {iwait, dwait}); failures++;
    end
    checks++;
    if ({ramREN, ramWEN} !== 2'b00) begin
      $display("[TB] FAIL reset_strobes: got %b expected 00", {ramREN, ramWEN}); failures++;
    end
    checks++;
    if ({ramaddr, ramstore} !== 64'h0) begin
      $display("[TB] FAIL reset_ram_bus: got %h expected 0", {ramaddr, ramstore}); failures++;
    end
    checks++;
    if ({iload, dload, mem_err} !== 65'h0) begin
      $display("[TB] FAIL reset_loads_err: got %h expected 0", {iload, dload, mem_err}); failures++;
    end
    nextCycle();
    nRST = 1'b1;
  endtask

  task automatic test_iread_min();
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = FREE; ramload = 32'h5555_AAAA;
    sample();
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin
      $display("[TB] FAIL iread_c0: got ramREN,iwait=%b expected 01", {ramREN, iwait}); failures++;
    end
    nextCycle();
    ramstate = ACCESS; ramload = 32'h2401_0005;
    sample();
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h0000_0040}) begin
      $display("[TB] FAIL iread_strobe: got %b %h expected 10 00000040", {ramREN, ramWEN}, ramaddr); failures++;
    end
    checks++;
    if ({iwait, iload} !== {1'b0, 32'h2401_0005}) begin
      $display("[TB] FAIL iread_load: got iwait=%b iload=%h expected 0 24010005", iwait, iload); failures++;
    end
    checks++;
    if ({dwait, dload} !== {1'b1, 32'h0}) begin
      $display("[TB] FAIL iread_dport_idle: got dwait=%b dload=%h expected 1 0", dwait, dload); failures++;
    end
    nextCycle();
    iREN = 1'b0; ramstate = FREE;
    sample();
    checks++;
    if ({ramREN, iwait, dwait} !== 3'b011) begin
      $display("[TB] FAIL iread_idle_after: got %b expected 011", {ramREN, iwait, dwait}); failures++;
    end
  endtask

  task automatic test_priority();
    nextCycle();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h0000_0080; daddr = 32'h0000_0200; ramstate = BUSY;
    for (int c = 1; c <= 2; c++) begin
      nextCycle(); sample();
      checks++;
      if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h0000_0200, 2'b11}) begin
        $display("[TB] FAIL prio_dbusy_c%0d: got %b %h %b expected 1 00000200 11", c, ramREN, ramaddr, {iwait, dwait}); failures++;
      end
    end
    nextCycle();
    ramstate = ACCESS; ramload = 32'h1111_2222;
    sample();
    checks++;
    if ({dwait, dload, iwait} !== {1'b0, 32'h1111_2222, 1'b1}) begin
      $display("[TB] FAIL prio_d_done_c3: got dwait=%b dload=%h iwait=%b expected 0 11112222 1", dwait, dload, iwait); failures++;
    end
    nextCycle();
    dREN = 1'b0; ramstate = BUSY;
    sample();
    checks++;
    if (ramREN !== 1'b0) begin
      $display("[TB] FAIL prio_idle_c4: got ramREN=%b expected 0", ramREN); failures++;
    end
    nextCycle(); sample();
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h0000_0080, 1'b1}) begin
      $display("[TB] FAIL prio_i_c5: got %b %h %b expected 1 00000080 1", ramREN, ramaddr, iwait); failures++;
    end
    nextCycle(); nextCycle();
    ramstate = ACCESS; ramload = 32'h3333_4444;
    sample();
    checks++;
    if ({iwait, iload} !== {1'b0, 32'h3333_4444}) begin
      $display("[TB] FAIL prio_i_done_c7: got iwait=%b iload=%h expected 0 33334444", iwait, iload); failures++;
    end
    nextCycle();
    iREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_write();
    nextCycle();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF; ramstate = ACCESS;
    nextCycle(); sample();
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h0000_0100, 32'hDEAD_BEEF}) begin
      $display("[TB] FAIL write_bus: got %b %h %h expected 10 00000100 deadbeef", {ramWEN, ramREN}, ramaddr, ramstore); failures++;
    end
    checks++;
    if ({dwait, mem_err} !== 2'b00) begin
      $display("[TB] FAIL write_done: got dwait,mem_err=%b expected 00", {dwait, mem_err}); failures++;
    end
    nextCycle();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_drop();
    nextCycle();
    dREN = 1'b1; daddr = 32'h0000_0400; ramstate = BUSY; ramload = 32'h7777_8888;
    nextCycle(); sample();
    checks++;
    if ({ramREN, dwait} !== 2'b11) begin
      $display("[TB] FAIL drop_busy: got %b expected 11", {ramREN, dwait}); failures++;
    end
    nextCycle();
    dREN = 1'b0; ramstate = ACCESS;
    sample();
    checks++;
    if ({ramREN, dwait, dload} !== {2'b01, 32'h0}) begin
      $display("[TB] FAIL drop_same_cycle: got %b %b %h expected 0 1 0", ramREN, dwait, dload); failures++;
    end
    nextCycle();
    ramstate = FREE;
  endtask

  task automatic test_error_sticky();
    nextCycle();
    dREN = 1'b1; daddr = 32'h0000_0300; ramstate = FREE;
    nextCycle();
    ramstate = ERROR; ramload = 32'hFFFF_FFFF;
    sample();
    checks++;
    if ({ramREN, dwait, dload} !== {2'b10, 32'h0}) begin
      $display("[TB] FAIL err_complete: got %b %b %h expected 1 0 0", ramREN, dwait, dload); failures++;
    end
    nextCycle();
    dREN = 1'b0; ramstate = FREE;
    sample();
    checks++;
    if ({mem_err, dwait} !== 2'b11) begin
      $display("[TB] FAIL err_flag_set: got mem_err,dwait=%b expected 11", {mem_err, dwait}); failures++;
    end
    nextCycle();
    dREN = 1'b1; daddr = 32'h0000_0304;
    nextCycle();
    ramstate = ACCESS; ramload = 32'hCAFE_0001;
    sample();
    checks++;
    if ({dwait, dload} !== {1'b0, 32'hCAFE_0001}) begin
      $display("[TB] FAIL err_good_read: got dwait=%b dload=%h expected 0 cafe0001", dwait, dload); failures++;
    end
    nextCycle();
    dREN = 1'b0; ramstate = FREE;
    sample();
    checks++;
    if (mem_err !== 1'b1) begin
      $display("[TB] FAIL err_sticky: got mem_err=%b expected 1", mem_err); failures++;
    end
  endtask

  task automatic test_reset_mid_write();
    nextCycle();
    dWEN = 1'b1; daddr = 32'h0000_0500; dstore = 32'h1234_5678; ramstate = BUSY;
    nextCycle(); sample();
    checks++;
    if ({ramWEN, dwait, mem_err} !== 3'b111) begin
      $display("[TB] FAIL rst_mid_pre: got %b expected 111", {ramWEN, dwait, mem_err}); failures++;
    end
    nextCycle();
    nRST = 1'b0;
    nextCycle();
    nRST = 1'b1;
    sample();
    checks++;
    if ({ramWEN, dwait, mem_err, ramaddr, ramstore} !== {3'b010, 64'h0}) begin
      $display("[TB] FAIL rst_mid_post: got %b %h %h expected 010 0 0", {ramWEN, dwait, mem_err}, ramaddr, ramstore); failures++;
    end
    dWEN = 1'b0;
    nextCycle();
    ramstate = FREE;
  endtask

  task automatic test_fairness();
    logic [31:0] expAddr [6];
`ifdef MEMCTRL_FAIRNESS_EN
    expAddr = '{32'h100, 32'h100, 32'h40, 32'h100, 32'h100, 32'h40};
`else
    expAddr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
`endif
    nRST = 1'b0;
    nextCycle();
    nRST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h0000_0040; daddr = 32'h0000_0100; ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    for (int g = 0; g < 6; g++) begin
      nextCycle(); sample();
      checks++;
      if ({ramREN, ramaddr} !== {1'b1, expAddr[g]}) begin
        $display("[TB] FAIL grant_%0d: got ramREN=%b ramaddr=%h expected 1 %h", g, ramREN, ramaddr, expAddr[g]); failures++;
      end
      nextCycle();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_iread_min();
    test_priority();
    test_write();
    test_drop();
    test_error_sticky();
    test_reset_mid_write();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
